cutelock_b09_sequencer: RTL and testbench

- Run-time controller for a key-locked serial-converter core (ITC99 b09 class) whose key input must follow a per-cycle schedule locked to the core's internal state counter.
- Holds a programmable key schedule of DEPTH entries and replays it cyclically on `key_out` while running.
- Serializes byte-wide host data into framed bits on `x_out`, which drives the core's serial input `X`.
- Sits between the test/host harness and the locked core, on the same single clock.

---
 rtl/cutelock_b09_sequencer_if.sv | 32 +++
 rtl/cutelock_b09_sequencer.sv | 208 ++++++++++++++++++++
 tb/tb_cutelock_b09_sequencer.sv | 271 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/cutelock_b09_sequencer_if.sv
// Host-side bus of the cutelock b09 sequencer: schedule load, run control,
// byte stream in, and the serial/key drive toward the locked core.
interface cutelock_b09_sequencer_if #(
   parameter int KEY_W = 1,
   parameter int PH_W  = 1
);
   logic             cfg_valid;
   logic [KEY_W-1:0] cfg_data;
   logic             cfg_ready;
   logic             start;
   logic             stop;
   logic             byte_valid;
   logic [7:0]       byte_data;
   logic             byte_ready;
   logic             x_out;
   logic [KEY_W-1:0] key_out;
   logic [PH_W-1:0]  phase;
   logic             busy;
   logic             cfg_err;

   // Host / harness side
   modport master (
      output cfg_valid, cfg_data, start, stop, byte_valid, byte_data,
      input  cfg_ready, byte_ready, x_out, key_out, phase, busy, cfg_err
   );

   // Sequencer side
   modport slave (
      input  cfg_valid, cfg_data, start, stop, byte_valid, byte_data,
      output cfg_ready, byte_ready, x_out, key_out, phase, busy, cfg_err
   );
endinterface

// File: rtl/cutelock_b09_sequencer.sv
// Run-time controller for a key-locked b09-class serial converter.
// Loads a DEPTH-entry key schedule, replays it on key_out while running,
// and frames host bytes onto x_out (start bit, 8 data bits MSB first,
// then 1 + GAP zero cycles).
// Optional feature macro: CUTELOCK_PHASE_SYNC_EN adds sync_in, which
// realigns the schedule phase to 0 while running or draining.
module cutelock_b09_sequencer #(
   parameter int DEPTH = 2,
   parameter int KEY_W = 1,
   parameter int PH_W  = 1,
   parameter int GAP   = 2
) (
   input logic clock,
   input logic reset,
`ifdef CUTELOCK_PHASE_SYNC_EN
   input logic sync_in,
`endif
   cutelock_b09_sequencer_if.slave bus
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_ARMED,
      S_RUN,
      S_DRAIN
   } state_t;

   // Frame counter holds the cycle offset from byte acceptance; 0 = idle.
   localparam int              CNT_W     = $clog2(11 + GAP);
   localparam logic [CNT_W-1:0] CNT_START = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_D0    = CNT_W'(2);
   localparam logic [CNT_W-1:0] CNT_D7    = CNT_W'(9);
   localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(10 + GAP);
   localparam logic [PH_W-1:0]  PH_LAST   = PH_W'(DEPTH - 1);

   state_t           state_q, state_d;
   logic [KEY_W-1:0] sched_q [DEPTH];
   logic [KEY_W-1:0] sched_d [DEPTH];
   logic [PH_W-1:0]  wr_ptr_q, wr_ptr_d;
   logic [PH_W-1:0]  phase_q, phase_d;
   logic             loaded_q, loaded_d;
   logic [KEY_W-1:0] key_q, key_d;
   logic             cfg_err_q, cfg_err_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [7:0]       data_q, data_d;

   logic             cfg_ready;
   logic             byte_ready;
   logic             byte_acc;
   logic             frame_active;
   logic             frame_last;
   logic             sync_hit;
   logic [PH_W-1:0]  phase_nxt;

`ifdef CUTELOCK_PHASE_SYNC_EN
   assign sync_hit = sync_in;
`else
   assign sync_hit = 1'b0;
`endif

   assign frame_active = (cnt_q != '0);
   assign frame_last   = (cnt_q == CNT_LAST);
   assign phase_nxt    = (phase_q == PH_LAST) ? '0 : phase_q + PH_W'(1);

   // Control FSM: schedule loading, run/drain sequencing, phase and key.
   always_comb begin
      // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latches).
      state_d    = state_q;
      sched_d    = sched_q;
      wr_ptr_d   = wr_ptr_q;
      phase_d    = phase_q;
      loaded_d   = loaded_q;
      key_d      = key_q;
      cfg_err_d  = cfg_err_q;
      cfg_ready  = 1'b0;
      byte_ready = 1'b0;
      byte_acc   = 1'b0;

      case (state_q)
         S_IDLE: begin
            cfg_ready = 1'b1;
            if (bus.start) begin
               cfg_err_d = 1'b1;
            end
            if (bus.cfg_valid) begin
               sched_d[wr_ptr_q] = bus.cfg_data;
               if (wr_ptr_q == PH_LAST) begin
                  wr_ptr_d = '0;
                  loaded_d = 1'b1;
                  state_d  = S_ARMED;
               end else begin
                  wr_ptr_d = wr_ptr_q + PH_W'(1);
               end
            end
         end

         S_ARMED: begin
            if (bus.start && loaded_q) begin
               // Start wins over a simultaneous cfg beat; cfg_ready stays low.
               state_d = S_RUN;
               phase_d = '0;
               key_d   = sched_q[0];
            end else begin
               cfg_ready = 1'b1;
               if (bus.cfg_valid) begin
                  // A new beat discards the old schedule and restarts loading.
                  sched_d[0] = bus.cfg_data;
                  wr_ptr_d   = PH_W'(1);
                  loaded_d   = 1'b0;
                  state_d    = S_IDLE;
               end
            end
         end

         S_RUN: begin
            byte_ready = !frame_active;
            byte_acc   = bus.byte_valid && byte_ready;
            phase_d    = phase_nxt;
            key_d      = sched_q[phase_nxt];
            if (sync_hit) begin
               phase_d = '0;
               key_d   = sched_q[0];
            end
            if (bus.stop) begin
               if (frame_active || byte_acc) begin
                  state_d = S_DRAIN;
               end else begin
                  state_d = S_ARMED;
                  phase_d = '0;
                  key_d   = '0;
               end
            end
         end

         S_DRAIN: begin
            phase_d = phase_nxt;
            key_d   = sched_q[phase_nxt];
            if (sync_hit) begin
               phase_d = '0;
               key_d   = sched_q[0];
            end
            if (frame_last || !frame_active) begin
               state_d = S_ARMED;
               phase_d = '0;
               key_d   = '0;
            end
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // Serializer: counts frame cycles and shifts data out MSB first.
   always_comb begin
      cnt_d  = cnt_q;
      data_d = data_q;
      if (byte_acc) begin
         cnt_d  = CNT_START;
         data_d = bus.byte_data;
      end else if (frame_active) begin
         cnt_d = frame_last ? '0 : cnt_q + CNT_W'(1);
         if (cnt_q >= CNT_D0) begin
            data_d = {data_q[6:0], 1'b0};
         end
      end
   end

   // State and datapath registers.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q   <= S_IDLE;
         // NOTE: the schedule array is reset explicitly so a reset leaves no stale key material behind.
         for (int i = 0; i < DEPTH; i++) begin
            sched_q[i] <= '0;
         end
         wr_ptr_q  <= '0;
         phase_q   <= '0;
         loaded_q  <= 1'b0;
         key_q     <= '0;
         cfg_err_q <= 1'b0;
         cnt_q     <= '0;
         data_q    <= '0;
      end else begin
         // NOTE: non-blocking assignments so every flop samples the pre-edge values.
         state_q   <= state_d;
         sched_q   <= sched_d;
         wr_ptr_q  <= wr_ptr_d;
         phase_q   <= phase_d;
         loaded_q  <= loaded_d;
         key_q     <= key_d;
         cfg_err_q <= cfg_err_d;
         cnt_q     <= cnt_d;
         data_q    <= data_d;
      end
   end

   assign bus.cfg_ready  = cfg_ready;
   assign bus.byte_ready = byte_ready;
   assign bus.x_out      = (cnt_q == CNT_START) ||
                           ((cnt_q >= CNT_D0) && (cnt_q <= CNT_D7) && data_q[7]);
   assign bus.key_out    = key_q;
   assign bus.phase      = phase_q;
   assign bus.busy       = (state_q == S_RUN) || (state_q == S_DRAIN);
   assign bus.cfg_err    = cfg_err_q;

endmodule

// File: tb/tb_cutelock_b09_sequencer.sv
// Self-checking bench for cutelock_b09_sequencer (DEPTH=2, KEY_W=1,
// PH_W=1, GAP=2). Table of per-cycle vectors for load/run/frame, then
// hand sequences for drain, schedule restart, mid-frame reset, cfg_err.
module tb_cutelock_b09_sequencer;

   localparam int KEY_W = 1;
   localparam int PH_W  = 1;

   typedef struct {
      logic       cv;
      logic       cd;
      logic       st;
      logic       sp;
      logic       bv;
      logic [7:0] bd;
      logic       cr;
      logic       br;
      logic       x;
      logic       key;
      logic       ph;
      logic       busy;
      logic       err;
   } vec_t;

   logic clock;
   logic reset;
   logic sync_in;
   int   n_checks;
   int   n_err;
   vec_t vecs [21];

   cutelock_b09_sequencer_if #(.KEY_W(KEY_W), .PH_W(PH_W)) bus ();

   cutelock_b09_sequencer #(
      .DEPTH(2),
      .KEY_W(KEY_W),
      .PH_W (PH_W),
      .GAP  (2)
   ) dut (
      .clock  (clock),
      .reset  (reset),
`ifdef CUTELOCK_PHASE_SYNC_EN
      .sync_in(sync_in),
`endif
      .bus    (bus)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic expect_outs(input string tag, input logic cr, input logic br, input logic x,
                              input logic key, input logic ph, input logic busy, input logic err);
      check({tag, " cfg_ready"},  bus.cfg_ready,  cr);
      check({tag, " byte_ready"}, bus.byte_ready, br);
      check({tag, " x_out"},      bus.x_out,      x);
      check({tag, " key_out"},    bus.key_out,    key);
      check({tag, " phase"},      bus.phase,      ph);
      check({tag, " busy"},       bus.busy,       busy);
      check({tag, " cfg_err"},    bus.cfg_err,    err);
   endtask

   task automatic drive(input logic cv, input logic cd, input logic st, input logic sp,
                        input logic bv, input logic [7:0] bd);
      bus.cfg_valid  = cv;
      bus.cfg_data   = cd;
      bus.start      = st;
      bus.stop       = sp;
      bus.byte_valid = bv;
      bus.byte_data  = bd;
   endtask

   task automatic idle_in();
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic set_vec(input int i, input logic cv, input logic cd, input logic st, input logic sp,
                          input logic bv, input logic [7:0] bd, input logic cr, input logic br,
                          input logic x, input logic key, input logic ph, input logic busy,
                          input logic err);
      vecs[i] = '{cv, cd, st, sp, bv, bd, cr, br, x, key, ph, busy, err};
   endtask

   initial begin
      logic [7:0] b;
      n_checks = 0;
      n_err    = 0;
      sync_in  = 1'b0;
      reset    = 1'b0;
      idle_in();

      //            cv cd st sp bv bd     cr br x  key ph busy err
      set_vec( 0,   1, 1, 0, 0, 0, 8'h00, 1, 0, 0, 0,  0, 0,   0);
      set_vec( 1,   1, 0, 0, 0, 0, 8'h00, 1, 0, 0, 0,  0, 0,   0);
      set_vec( 2,   0, 0, 1, 0, 0, 8'h00, 0, 0, 0, 0,  0, 0,   0);
      set_vec( 3,   0, 0, 0, 0, 0, 8'h00, 0, 1, 0, 1,  0, 1,   0);
      set_vec( 4,   0, 0, 0, 0, 0, 8'h00, 0, 1, 0, 0,  1, 1,   0);
      set_vec( 5,   0, 0, 0, 0, 0, 8'h00, 0, 1, 0, 1,  0, 1,   0);
      set_vec( 6,   0, 0, 0, 0, 0, 8'h00, 0, 1, 0, 0,  1, 1,   0);
      set_vec( 7,   0, 0, 0, 0, 1, 8'hA5, 0, 1, 0, 1,  0, 1,   0);
      set_vec( 8,   0, 0, 0, 0, 0, 8'h00, 0, 0, 1, 0,  1, 1,   0);
      set_vec( 9,   0, 0, 0, 0, 0, 8'h00, 0, 0, 1, 1,  0, 1,   0);
      set_vec(10,   0, 0, 0, 0, 0, 8'h00, 0, 0, 0, 0,  1, 1,   0);
      set_vec(11,   0, 0, 0, 0, 0, 8'h00, 0, 0, 1, 1,  0, 1,   0);
      set_vec(12,   0, 0, 0, 0, 0, 8'h00, 0, 0, 0, 0,  1, 1,   0);
      set_vec(13,   0, 0, 0, 0, 0, 8'h00, 0, 0, 0, 1,  0, 1,   0);
      set_vec(14,   0, 0, 0, 0, 0, 8'h00, 0, 0, 1, 0,  1, 1,   0);
      set_vec(15,   0, 0, 0, 0, 0, 8'h00, 0, 0, 0, 1,  0, 1,   0);
      set_vec(16,   0, 0, 0, 0, 0, 8'h00, 0, 0, 1, 0,  1, 1,   0);
      set_vec(17,   0, 0, 0, 0, 0, 8'h00, 0, 0, 0, 1,  0, 1,   0);
      set_vec(18,   0, 0, 0, 0, 0, 8'h00, 0, 0, 0, 0,  1, 1,   0);
      set_vec(19,   0, 0, 0, 0, 0, 8'h00, 0, 0, 0, 1,  0, 1,   0);
      set_vec(20,   0, 0, 0, 0, 0, 8'h00, 0, 1, 0, 0,  1, 1,   0);

      // Values while reset is held
      #2;
      expect_outs("in_reset", 1, 0, 0, 0, 0, 0, 0);
      @(negedge clock);
      reset = 1'b1;
      tick();

      // Load 1,0; start; key/phase replay; 0xA5 frame timing
      for (int i = 0; i < 21; i++) begin
         drive(vecs[i].cv, vecs[i].cd, vecs[i].st, vecs[i].sp, vecs[i].bv, vecs[i].bd);
         #1;
         expect_outs($sformatf("vec%0d", i), vecs[i].cr, vecs[i].br, vecs[i].x,
                     vecs[i].key, vecs[i].ph, vecs[i].busy, vecs[i].err);
         tick();
      end

      // Accept 0x3C at t, stop at t+1, drain through the gap, land in ARMED
      b = 8'h3C;
      drive(0, 0, 0, 0, 1, b);
      #1;
      check("drain t byte_ready", bus.byte_ready, 1'b1);
      tick();
      drive(0, 0, 0, 1, 0, 8'h00);
      #1;
      check("drain t+1 x_out", bus.x_out, 1'b1);
      check("drain t+1 busy", bus.busy, 1'b1);
      tick();
      idle_in();
      for (int k = 2; k <= 12; k++) begin
         #1;
         check($sformatf("drain t+%0d x_out", k), bus.x_out, (k <= 9) ? b[9-k] : 1'b0);
         check($sformatf("drain t+%0d byte_ready", k), bus.byte_ready, 1'b0);
         check($sformatf("drain t+%0d busy", k), bus.busy, 1'b1);
         check($sformatf("drain t+%0d phase", k), bus.phase, k % 2);
         tick();
      end
      #1;
      expect_outs("drain_done", 1, 0, 0, 0, 0, 0, 0);

      // Restart load from ARMED with 0,1; start with a colliding cfg beat
      drive(1, 0, 0, 0, 0, 8'h00);
      tick();
      drive(1, 1, 0, 0, 0, 8'h00);
      #1;
      check("reload cfg_ready", bus.cfg_ready, 1'b1);
      check("reload busy", bus.busy, 1'b0);
      tick();
      drive(1, 1, 1, 0, 0, 8'h00);
      #1;
      check("start_vs_cfg cfg_ready", bus.cfg_ready, 1'b0);
      tick();
      idle_in();
      #1;
      expect_outs("reload_run0", 0, 1, 0, 0, 0, 1, 0);
      tick();
      #1;
      check("reload_run1 key_out", bus.key_out, 1'b1);
      check("reload_run1 phase", bus.phase, 1'b1);
      tick();

      // Mid-frame reset at t+4 of 0xFF
      drive(0, 0, 0, 0, 1, 8'hFF);
      #1;
      check("rst_frame t key_out", bus.key_out, 1'b0);
      check("rst_frame t byte_ready", bus.byte_ready, 1'b1);
      tick();
      idle_in();
      tick();
      tick();
      tick();
      #1;
      check("rst_frame t+4 x_out", bus.x_out, 1'b1);
      #2;
      reset = 1'b0;
      #1;
      expect_outs("rst_async", 1, 0, 0, 0, 0, 0, 0);
      tick();
      expect_outs("rst_held", 1, 0, 0, 0, 0, 0, 0);
      @(negedge clock);
      reset = 1'b1;
      tick();

      // One beat then start: cfg_err, stay IDLE; then finish load and run
      drive(1, 1, 0, 0, 0, 8'h00);
      #1;
      check("err_pre cfg_err", bus.cfg_err, 1'b0);
      tick();
      drive(0, 0, 1, 0, 0, 8'h00);
      #1;
      check("err_start cfg_ready", bus.cfg_ready, 1'b1);
      tick();
      drive(1, 0, 0, 0, 0, 8'h00);
      #1;
      expect_outs("err_set", 1, 0, 0, 0, 0, 0, 1);
      tick();
      drive(0, 0, 1, 0, 0, 8'h00);
      #1;
      check("err_armed cfg_ready", bus.cfg_ready, 1'b0);
      check("err_armed busy", bus.busy, 1'b0);
      tick();
      idle_in();
      #1;
      expect_outs("err_run0", 0, 1, 0, 1, 0, 1, 1);
      tick();
`ifdef CUTELOCK_PHASE_SYNC_EN
      sync_in = 1'b1;
`endif
      #1;
      check("run1 key_out", bus.key_out, 1'b0);
      check("run1 phase", bus.phase, 1'b1);
      tick();
      sync_in = 1'b0;
      #1;
      check("run2 key_out", bus.key_out, 1'b1);
      check("run2 phase", bus.phase, 1'b0);
`ifdef CUTELOCK_PHASE_SYNC_EN
      sync_in = 1'b1;
`endif
      tick();
      sync_in = 1'b0;
      drive(0, 0, 0, 1, 0, 8'h00);
      #1;
`ifdef CUTELOCK_PHASE_SYNC_EN
      check("sync_hold key_out", bus.key_out, 1'b1);
      check("sync_hold phase", bus.phase, 1'b0);
`else
      check("run3 key_out", bus.key_out, 1'b0);
      check("run3 phase", bus.phase, 1'b1);
`endif
      tick();
      idle_in();
      #1;
      expect_outs("stop_no_frame", 1, 0, 0, 0, 0, 0, 1);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
